// File: rtl/imem_loader.sv
// Debug-port loader for the instruction memory: packs received bytes MSB-first
// into words and writes them to consecutive addresses until HALT_WORD or a full memory.
module imem_loader #(
    parameter int                  LEN_DATA  = 32,
    parameter int                  LEN_ADDR  = 7,
    parameter logic [LEN_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_load_req,
    input  logic [7:0]          in_rx_data,
    input  logic                in_rx_valid,
    output logic                out_debug_flag,
    output logic [LEN_ADDR-1:0] out_addr_debug,
    output logic [LEN_DATA-1:0] out_ins_to_mem,
    output logic                out_wea_ram_inst,
    output logic                out_load_done,
    output logic                out_overflow,
    output logic [LEN_ADDR:0]   out_word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [1:0]          byte_cnt_r;
    logic [LEN_DATA-1:0] shift_r;
    logic [LEN_ADDR-1:0] addr_r;
    logic [LEN_DATA-1:0] data_r;
    logic                wea_r;
    logic                flag_r;
    logic                done_r;
    logic                ovf_r;
    logic [LEN_ADDR:0]   count_r;
    logic                last_byte_s;
    logic                halt_s;
    logic                last_addr_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a terminating write wins over a dropped load request.
    always_comb begin
        next_state_s = state_r;
        last_byte_s  = in_rx_valid && (byte_cnt_r == 2'd3);
        halt_s       = (data_r == HALT_WORD);
        last_addr_s  = (addr_r == {LEN_ADDR{1'b1}});
        case (state_r)
            ST_IDLE: begin
                if (in_load_req) next_state_s = ST_RECV;
                else             next_state_s = ST_IDLE;
            end
            ST_RECV: begin
                if (!in_load_req)     next_state_s = ST_IDLE;
                else if (last_byte_s) next_state_s = ST_WRITE;
                else                  next_state_s = ST_RECV;
            end
            ST_WRITE: begin
                if (halt_s || last_addr_s) next_state_s = ST_DONE;
                else if (!in_load_req)     next_state_s = ST_IDLE;
                else                       next_state_s = ST_RECV;
            end
            ST_DONE: begin
                if (!in_load_req) next_state_s = ST_IDLE;
                else              next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath and registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= {LEN_DATA{1'b0}};
            addr_r     <= {LEN_ADDR{1'b0}};
            data_r     <= {LEN_DATA{1'b0}};
            wea_r      <= 1'b0;
            flag_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            count_r    <= {(LEN_ADDR+1){1'b0}};
        end else begin
            wea_r  <= (next_state_s == ST_WRITE);
            flag_r <= (next_state_s == ST_RECV) || (next_state_s == ST_WRITE);
            done_r <= (next_state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_load_req) begin
                        addr_r     <= {LEN_ADDR{1'b0}};
                        byte_cnt_r <= 2'd0;
                        count_r    <= {(LEN_ADDR+1){1'b0}};
                        ovf_r      <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (in_load_req && in_rx_valid) begin
                        shift_r    <= {shift_r[LEN_DATA-9:0], in_rx_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (last_byte_s) begin
                            data_r <= {shift_r[LEN_DATA-9:0], in_rx_data};
                        end
                    end
                end
                ST_WRITE: begin
                    count_r <= count_r + {{LEN_ADDR{1'b0}}, 1'b1};
                    if (halt_s) begin
                        ovf_r <= 1'b0;
                    end else if (last_addr_s) begin
                        ovf_r <= 1'b1;
                    end else begin
                        addr_r <= addr_r + {{(LEN_ADDR-1){1'b0}}, 1'b1};
                        // A strobe here starts the next word (counter is already 0).
                        if (in_load_req && in_rx_valid) begin
                            shift_r    <= {shift_r[LEN_DATA-9:0], in_rx_data};
                            byte_cnt_r <= 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    ovf_r <= ovf_r;
                end
                default: begin
                    byte_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign out_debug_flag   = flag_r;
    assign out_addr_debug   = addr_r;
    assign out_ins_to_mem   = data_r;
    assign out_wea_ram_inst = wea_r;
    assign out_load_done    = done_r;
    assign out_overflow     = ovf_r;
    assign out_word_count   = count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (LEN_ADDR=2 so the full-memory path is reachable).
module tb_imem_loader;

    localparam int LA = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_load_req;
    logic [7:0]    in_rx_data;
    logic          in_rx_valid;
    logic          out_debug_flag;
    logic [LA-1:0] out_addr_debug;
    logic [31:0]   out_ins_to_mem;
    logic          out_wea_ram_inst;
    logic          out_load_done;
    logic          out_overflow;
    logic [LA:0]   out_word_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [LA-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.LEN_DATA(32), .LEN_ADDR(LA), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_load_req      (in_load_req),
        .in_rx_data       (in_rx_data),
        .in_rx_valid      (in_rx_valid),
        .out_debug_flag   (out_debug_flag),
        .out_addr_debug   (out_addr_debug),
        .out_ins_to_mem   (out_ins_to_mem),
        .out_wea_ram_inst (out_wea_ram_inst),
        .out_load_done    (out_load_done),
        .out_overflow     (out_overflow),
        .out_word_count   (out_word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every wea pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && out_wea_ram_inst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h expected none",
                         out_addr_debug, out_ins_to_mem);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(out_addr_debug), 32'(e.addr));
                chk("wr_data", out_ins_to_mem, e.data);
                chk("wr_flag", 32'(out_debug_flag), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_rx_data  = b;
        in_rx_valid = 1'b1;
        tick();
        in_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic push(input logic [LA-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_status(input string tag, input logic flag, input logic done,
                              input logic ovf, input logic [LA:0] cnt);
        chk({tag, "_flag"},  32'(out_debug_flag), 32'(flag));
        chk({tag, "_done"},  32'(out_load_done),  32'(done));
        chk({tag, "_ovf"},   32'(out_overflow),   32'(ovf));
        chk({tag, "_count"}, 32'(out_word_count), 32'(cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 3'd0);
        chk({tag, "_wea"},  32'(out_wea_ram_inst), 32'd0);
        chk({tag, "_addr"}, 32'(out_addr_debug),   32'd0);
        chk({tag, "_data"}, out_ins_to_mem,        32'd0);
    endtask

    task automatic restart();
        in_load_req = 1'b0;
        tick();
        in_load_req = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_load_req = 1'b0;
        in_rx_data  = 8'h00;
        in_rx_valid = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // 1: single word; the strobe on the IDLE->RECV cycle is ignored
        in_load_req = 1'b1;
        send_byte(8'h77);
        push(2'd0, 32'h2008_0005);
        send_word(32'h2008_0005);
        tick();
        chk_status("t1", 1'b1, 1'b0, 1'b0, 3'd1);
        chk("t1_wea", 32'(out_wea_ram_inst), 32'd0);

        // 2: three words then HALT at the last address -> no overflow
        restart();
        push(2'd0, 32'h0000_0001);
        push(2'd1, 32'h1234_5678);
        push(2'd2, 32'hDEAD_BEEF);
        push(2'd3, 32'hFFFF_FFFF);
        send_word(32'h0000_0001); tick();
        send_word(32'h1234_5678); tick();
        send_word(32'hDEAD_BEEF); tick();
        send_word(32'hFFFF_FFFF); tick();
        chk_status("t2", 1'b0, 1'b1, 1'b0, 3'd4);
        send_word(32'hFFFF_FFFF);
        tick();
        in_load_req = 1'b0;
        tick();
        chk_status("t2_idle", 1'b0, 1'b0, 1'b0, 3'd4);

        // 3: fill memory without HALT -> overflow; a 5th word is ignored
        in_load_req = 1'b1;
        tick();
        chk_status("t3_start", 1'b1, 1'b0, 1'b0, 3'd0);
        push(2'd0, 32'hA0A0_0000);
        push(2'd1, 32'hA1A1_1111);
        push(2'd2, 32'hA2A2_2222);
        push(2'd3, 32'hA3A3_3333);
        send_word(32'hA0A0_0000); tick();
        send_word(32'hA1A1_1111); tick();
        send_word(32'hA2A2_2222); tick();
        send_word(32'hA3A3_3333); tick();
        chk_status("t3", 1'b0, 1'b1, 1'b1, 3'd4);
        send_word(32'hB4B4_4444);
        tick();
        chk_status("t3_after", 1'b0, 1'b1, 1'b1, 3'd4);
        chk("t3_addr", 32'(out_addr_debug), 32'd3);

        // 4: partial word discarded on req drop; next session uses fresh bytes
        restart();
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_load_req = 1'b0;
        tick();
        chk_status("t4_abort", 1'b0, 1'b0, 1'b0, 3'd0);
        in_load_req = 1'b1;
        tick();
        push(2'd0, 32'h1122_3344);
        send_word(32'h1122_3344);
        tick();
        chk_status("t4", 1'b1, 1'b0, 1'b0, 3'd1);

        // 5: strobe in WRITE becomes MSB of next word; dropped when session ends
        push(2'd1, 32'h5566_7788);
        push(2'd2, 32'h99AA_BBCC);
        push(2'd3, 32'h0102_0304);
        send_word(32'h5566_7788);
        send_byte(8'h99);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        tick();
        send_word(32'h0102_0304);
        send_byte(8'h42);
        chk_status("t5", 1'b0, 1'b1, 1'b1, 3'd4);

        // 6: reset mid-word and during WRITE clears outputs immediately
        restart();
        send_byte(8'h10);
        send_byte(8'h20);
        chk("t6_flag_pre", 32'(out_debug_flag), 32'd1);
        reset = 1'b1;
        #1;
        chk_zero("t6_midword");
        reset = 1'b0;
        tick();
        send_word(32'hCAFE_F00D);
        chk("t6_wea_pre", 32'(out_wea_ram_inst), 32'd1);
        reset = 1'b1;
        #1;
        chk_zero("t6_write");
        #2;
        reset = 1'b0;
        tick();
        push(2'd0, 32'h0BAD_C0DE);
        send_word(32'h0BAD_C0DE);
        tick();
        chk_status("t6", 1'b1, 1'b0, 1'b0, 3'd1);

        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
